// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with forward muxing, load-use bubble FSM and bubble counter
module id_ex_operand_stage #(
  parameter int DATA_W = 10,
  parameter int REG_AW = 3,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [REG_AW-1:0] id_dest_reg,
  input  logic [REG_AW-1:0] id_src_reg,
  input  logic [DATA_W-1:0] id_dest_val,
  input  logic [DATA_W-1:0] id_src_val,
  input  logic              id_wr,
  input  logic              id_mem_rd,
  input  logic              forwardA,
  input  logic              forwardB,
  input  logic [DATA_W-1:0] fwd_value,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_opcode,
  output logic [REG_AW-1:0] ex_dest_reg,
  output logic [DATA_W-1:0] ex_opA,
  output logic [DATA_W-1:0] ex_opB,
  output logic              ex_wr,
  output logic              ex_mem_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic {ST_RUN, ST_LU_STALL} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_valid;
  logic [OP_W-1:0]   r_opcode;
  logic [REG_AW-1:0] r_dest_reg;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic              r_wr;
  logic              r_mem_rd;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic              w_lu_hazard;
  logic              w_bubble;
  logic              w_cnt_sat;

  assign w_opa = forwardA ? fwd_value : id_dest_val;
  assign w_opb = forwardB ? fwd_value : id_src_val;

  assign w_lu_hazard = r_valid & r_mem_rd & id_valid &
                       ((r_dest_reg == id_dest_reg) | (r_dest_reg == id_src_reg));
  // Only RUN may insert a bubble, so a stalled slot is never bubbled twice.
  assign w_bubble  = (r_state == ST_RUN) & w_lu_hazard;
  assign w_cnt_sat = &r_bubble_cnt;

  always_comb begin
    w_state_nxt = r_state;
    stall_id    = 1'b0;
    if (!reset) begin
      stall_id = hold | (w_bubble & ~flush);
      if (flush)
        w_state_nxt = ST_RUN;
      else if (hold)
        w_state_nxt = r_state;
      else if (w_bubble)
        w_state_nxt = ST_LU_STALL;
      else
        w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_RUN;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_dest_reg   <= '0;
      r_opa        <= '0;
      r_opb        <= '0;
      r_wr         <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_wr     <= 1'b0;
      r_mem_rd <= 1'b0;
    end else if (hold) begin
      r_valid <= r_valid;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_dest_reg <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_wr       <= 1'b0;
      r_mem_rd   <= 1'b0;
      if (!w_cnt_sat)
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end else begin
      r_valid    <= id_valid;
      r_opcode   <= id_opcode;
      r_dest_reg <= id_dest_reg;
      r_opa      <= w_opa;
      r_opb      <= w_opb;
      r_wr       <= id_wr & id_valid;
      r_mem_rd   <= id_mem_rd & id_valid;
    end
  end

  assign ex_valid    = r_valid;
  assign ex_opcode   = r_opcode;
  assign ex_dest_reg = r_dest_reg;
  assign ex_opA      = r_opa;
  assign ex_opB      = r_opb;
  assign ex_wr       = r_wr;
  assign ex_mem_rd   = r_mem_rd;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [2:0] id_dest_reg;
  logic [2:0] id_src_reg;
  logic [9:0] id_dest_val;
  logic [9:0] id_src_val;
  logic       id_wr;
  logic       id_mem_rd;
  logic       forwardA;
  logic       forwardB;
  logic [9:0] fwd_value;
  logic       flush;
  logic       hold;
  logic       stall_id;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic [2:0] ex_dest_reg;
  logic [9:0] ex_opA;
  logic [9:0] ex_opB;
  logic       ex_wr;
  logic       ex_mem_rd;
  logic [7:0] bubble_cnt;

  int total = 0;
  int bad   = 0;

  // Reference view of the execute slot and bookkeeping
  logic       m_valid;
  logic [3:0] m_op;
  logic [2:0] m_dest;
  logic [9:0] m_opa;
  logic [9:0] m_opb;
  logic       m_wr;
  logic       m_mrd;
  bit         m_in_stall;
  int         m_cnt;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_dest_reg(id_dest_reg), .id_src_reg(id_src_reg), .id_dest_val(id_dest_val),
    .id_src_val(id_src_val), .id_wr(id_wr), .id_mem_rd(id_mem_rd),
    .forwardA(forwardA), .forwardB(forwardB), .fwd_value(fwd_value),
    .flush(flush), .hold(hold), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_dest_reg(ex_dest_reg), .ex_opA(ex_opA),
    .ex_opB(ex_opB), .ex_wr(ex_wr), .ex_mem_rd(ex_mem_rd), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit model_hazard();
    return m_valid && m_mrd && id_valid && (m_dest == id_dest_reg || m_dest == id_src_reg);
  endfunction

  function automatic bit model_stall();
    if (reset) return 1'b0;
    return hold || (!m_in_stall && model_hazard() && !flush);
  endfunction

  task automatic tick();
    bit haz;
    haz = model_hazard();
    @(posedge clk);
    if (reset) begin
      {m_valid, m_op, m_dest, m_opa, m_opb, m_wr, m_mrd} = '0;
      m_in_stall = 0;
      m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_wr = 0; m_mrd = 0;
      m_in_stall = 0;
    end else if (hold) begin
      m_in_stall = m_in_stall;
    end else if (!m_in_stall && haz) begin
      {m_valid, m_op, m_dest, m_opa, m_opb, m_wr, m_mrd} = '0;
      m_in_stall = 1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else begin
      m_valid = id_valid;
      m_op    = id_opcode;
      m_dest  = id_dest_reg;
      m_opa   = forwardA ? fwd_value : id_dest_val;
      m_opb   = forwardB ? fwd_value : id_src_val;
      m_wr    = id_wr && id_valid;
      m_mrd   = id_mem_rd && id_valid;
      m_in_stall = 0;
    end
    #1;
  endtask

  task automatic set_id(input bit v, input int op, input int d, input int s,
                        input int dv, input int sv, input bit wr, input bit mrd);
    id_valid = v; id_opcode = op[3:0]; id_dest_reg = d[2:0]; id_src_reg = s[2:0];
    id_dest_val = dv[9:0]; id_src_val = sv[9:0]; id_wr = wr; id_mem_rd = mrd;
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; hold = 1; forwardA = 0; forwardB = 0; fwd_value = '0;
    set_id(1, 1, 1, 1, 1, 1, 1, 1);
    tick();
    #1;
    total++;
    if (stall_id !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_id); end
    tick();
    total++;
    if ({ex_valid, ex_opcode, ex_dest_reg, ex_opA, ex_opB, ex_wr, ex_mem_rd} !== '0) begin
      bad++; $display("FAIL reset_ex got=%h want=0",
                      {ex_valid, ex_opcode, ex_dest_reg, ex_opA, ex_opB, ex_wr, ex_mem_rd});
    end
    total++;
    if (bubble_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bubble_cnt); end
    reset = 0; hold = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_forward();
    set_id(1, 3, 2, 5, 'h011, 'h022, 1, 0);
    forwardA = 1; forwardB = 0; fwd_value = 10'h3FF;
    tick();
    total++;
    if (ex_opA !== 10'h3FF || ex_opB !== 10'h022) begin
      bad++; $display("FAIL fwd_ops got=%h/%h want=3ff/022", ex_opA, ex_opB);
    end
    total++;
    if (ex_valid !== 1 || ex_opcode !== 4'd3 || ex_dest_reg !== 3'd2 || ex_wr !== 1) begin
      bad++; $display("FAIL fwd_ctl got=v%0b op%0d d%0d wr%0b want=v1 op3 d2 wr1",
                      ex_valid, ex_opcode, ex_dest_reg, ex_wr);
    end
    forwardA = 0;
  endtask

  task automatic test_load_use();
    set_id(1, 7, 4, 0, 'h100, 'h101, 1, 1);
    tick();
    set_id(1, 5, 1, 4, 'h0AA, 'h0BB, 1, 0);
    #1;
    total++;
    if (stall_id !== 1) begin bad++; $display("FAIL lu_stall got=%0b want=1", stall_id); end
    tick();
    total++;
    if (ex_valid !== 0 || ex_wr !== 0 || ex_mem_rd !== 0 || bubble_cnt !== 8'd1) begin
      bad++; $display("FAIL lu_bubble got=v%0b wr%0b mr%0b cnt%0d want=v0 wr0 mr0 cnt1",
                      ex_valid, ex_wr, ex_mem_rd, bubble_cnt);
    end
    total++;
    if (stall_id !== 0) begin bad++; $display("FAIL lu_stall_once got=%0b want=0", stall_id); end
    forwardB = 1; fwd_value = 10'h155;
    tick();
    total++;
    if (ex_valid !== 1 || ex_dest_reg !== 3'd1 || ex_opA !== 10'h0AA || ex_opB !== 10'h155) begin
      bad++; $display("FAIL lu_latch got=v%0b d%0d a%h b%h want=v1 d1 a0aa b155",
                      ex_valid, ex_dest_reg, ex_opA, ex_opB);
    end
    forwardB = 0;
  endtask

  task automatic test_flush_hazard();
    set_id(1, 2, 6, 0, 'h010, 'h020, 1, 1);
    tick();
    set_id(1, 4, 0, 6, 'h030, 'h040, 1, 0);
    flush = 1;
    #1;
    total++;
    if (stall_id !== 0) begin bad++; $display("FAIL flush_stall got=%0b want=0", stall_id); end
    tick();
    flush = 0;
    total++;
    if (ex_valid !== 0 || ex_wr !== 0 || ex_mem_rd !== 0 || bubble_cnt !== 8'd1) begin
      bad++; $display("FAIL flush_ex got=v%0b wr%0b mr%0b cnt%0d want=v0 wr0 mr0 cnt1",
                      ex_valid, ex_wr, ex_mem_rd, bubble_cnt);
    end
    tick();
    total++;
    if (ex_valid !== 1 || ex_opcode !== 4'd4 || bubble_cnt !== 8'd1) begin
      bad++; $display("FAIL flush_resume got=v%0b op%0d cnt%0d want=v1 op4 cnt1",
                      ex_valid, ex_opcode, bubble_cnt);
    end
  endtask

  task automatic test_hold_stall();
    set_id(1, 9, 3, 0, 'h001, 'h002, 1, 1);
    tick();
    set_id(1, 6, 5, 3, 'h0C0, 'h0D0, 1, 0);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (stall_id !== 1) begin bad++; $display("FAIL hold_stall[%0d] got=%0b want=1", i, stall_id); end
      tick();
      total++;
      if (ex_valid !== 0 || bubble_cnt !== 8'd2) begin
        bad++; $display("FAIL hold_frozen[%0d] got=v%0b cnt%0d want=v0 cnt2", i, ex_valid, bubble_cnt);
      end
    end
    hold = 0;
    tick();
    total++;
    if (ex_valid !== 1 || ex_opcode !== 4'd6 || ex_dest_reg !== 3'd5 || bubble_cnt !== 8'd2) begin
      bad++; $display("FAIL hold_release got=v%0b op%0d d%0d cnt%0d want=v1 op6 d5 cnt2",
                      ex_valid, ex_opcode, ex_dest_reg, bubble_cnt);
    end
    #1;
    total++;
    if (stall_id !== 0) begin bad++; $display("FAIL hold_after got=%0b want=0", stall_id); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 5) != 0, $urandom_range(0, 15), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 1023),
             $urandom_range(0, 1), $urandom_range(0, 1));
      forwardA = $urandom_range(0, 1); forwardB = $urandom_range(0, 1);
      fwd_value = 10'($urandom_range(0, 1023));
      flush = $urandom_range(0, 9) == 0;
      hold  = $urandom_range(0, 7) == 0;
      reset = $urandom_range(0, 99) == 0;
      #1;
      total++;
      if (stall_id !== model_stall()) begin
        bad++; $display("FAIL rnd_stall[%0d] got=%0b want=%0b", n, stall_id, model_stall());
      end
      tick();
      total++;
      if ({ex_valid, ex_opcode, ex_dest_reg, ex_opA, ex_opB, ex_wr, ex_mem_rd} !==
          {m_valid, m_op, m_dest, m_opa, m_opb, m_wr, m_mrd} || bubble_cnt !== 8'(m_cnt)) begin
        bad++; $display("FAIL rnd_ex[%0d] got=%h cnt%0d want=%h cnt%0d", n,
                        {ex_valid, ex_opcode, ex_dest_reg, ex_opA, ex_opB, ex_wr, ex_mem_rd}, bubble_cnt,
                        {m_valid, m_op, m_dest, m_opa, m_opb, m_wr, m_mrd}, m_cnt);
      end
    end
    flush = 0; hold = 0; reset = 0; forwardA = 0; forwardB = 0;
  endtask

  task automatic test_saturation();
    int bubbles;
    bubbles = 0;
    reset = 1;
    tick();
    reset = 0;
    set_id(1, 8, 1, 1, 'h005, 'h006, 1, 1);
    tick();
    for (int n = 0; n < 260; n++) begin
      #1;
      if (stall_id) bubbles++;
      tick();
      tick();
    end
    total++;
    if (bubbles !== 260) begin bad++; $display("FAIL sat_hazards got=%0d want=260", bubbles); end
    total++;
    if (bubble_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d want=255", bubble_cnt); end
  endtask

  initial begin
    reset = 1;
    test_reset();
    test_forward();
    test_load_use();
    test_flush_hazard();
    test_hold_stall();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
